// File: rtl/instr_compressor.sv
// instr_compressor: splits 32-bit instructions into three fields, looks each up in a
// loadable dictionary and emits a packed key triple on a full hit, else the raw word.
`default_nettype none

module instr_compressor #(
    parameter int FIELD1_VAL_WIDTH = 7,
    parameter int FIELD2_VAL_WIDTH = 10,
    parameter int FIELD3_VAL_WIDTH = 15,
    parameter int FIELD1_KEY_WIDTH = 3,
    parameter int FIELD2_KEY_WIDTH = 5,
    parameter int FIELD3_KEY_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        dict_clear,
    input  logic                        dict1_write_enable,
    input  logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    input  logic                        dict2_write_enable,
    input  logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    input  logic                        dict3_write_enable,
    input  logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
    output logic                        dict_overflow,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_hit,
    output logic [31:0]                 out_data,
    output logic [31:0]                 stat_total,
    output logic [31:0]                 stat_hits
);

    localparam int D1     = 1 << FIELD1_KEY_WIDTH;
    localparam int D2     = 1 << FIELD2_KEY_WIDTH;
    localparam int D3     = 1 << FIELD3_KEY_WIDTH;
    localparam int KEYS_W = FIELD1_KEY_WIDTH + FIELD2_KEY_WIDTH + FIELD3_KEY_WIDTH;
    localparam logic [FIELD1_KEY_WIDTH:0] FULL1 = (FIELD1_KEY_WIDTH+1)'(D1);
    localparam logic [FIELD2_KEY_WIDTH:0] FULL2 = (FIELD2_KEY_WIDTH+1)'(D2);
    localparam logic [FIELD3_KEY_WIDTH:0] FULL3 = (FIELD3_KEY_WIDTH+1)'(D3);

    logic [FIELD1_KEY_WIDTH:0]   ptr1_q;
    logic [FIELD2_KEY_WIDTH:0]   ptr2_q;
    logic [FIELD3_KEY_WIDTH:0]   ptr3_q;
    logic [D1-1:0]               vld1_q;
    logic [D2-1:0]               vld2_q;
    logic [D3-1:0]               vld3_q;
    logic [FIELD1_VAL_WIDTH-1:0] mem1_q [D1];
    logic [FIELD2_VAL_WIDTH-1:0] mem2_q [D2];
    logic [FIELD3_VAL_WIDTH-1:0] mem3_q [D3];
    logic                        overflow_q;

    logic                        s1_valid_q;
    logic [31:0]                 s1_instr_q;
    logic                        out_valid_q;
    logic                        out_hit_q;
    logic [31:0]                 out_data_q;
    logic [31:0]                 stat_total_q;
    logic [31:0]                 stat_hits_q;

    logic full1, full2, full3;
    logic wr1, wr2, wr3;
    logic stall, transfer;

    assign full1 = (ptr1_q == FULL1);
    assign full2 = (ptr2_q == FULL2);
    assign full3 = (ptr3_q == FULL3);
    assign wr1   = dict1_write_enable && !full1;
    assign wr2   = dict2_write_enable && !full2;
    assign wr3   = dict3_write_enable && !full3;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr1_q     <= '0;
            ptr2_q     <= '0;
            ptr3_q     <= '0;
            vld1_q     <= '0;
            vld2_q     <= '0;
            vld3_q     <= '0;
            overflow_q <= 1'b0;
        end else if (dict_clear) begin
            ptr1_q     <= '0;
            ptr2_q     <= '0;
            ptr3_q     <= '0;
            vld1_q     <= '0;
            vld2_q     <= '0;
            vld3_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr1) begin
                vld1_q[ptr1_q[FIELD1_KEY_WIDTH-1:0]] <= 1'b1;
                ptr1_q <= ptr1_q + 1'b1;
            end
            if (wr2) begin
                vld2_q[ptr2_q[FIELD2_KEY_WIDTH-1:0]] <= 1'b1;
                ptr2_q <= ptr2_q + 1'b1;
            end
            if (wr3) begin
                vld3_q[ptr3_q[FIELD3_KEY_WIDTH-1:0]] <= 1'b1;
                ptr3_q <= ptr3_q + 1'b1;
            end
            if ((dict1_write_enable && full1) || (dict2_write_enable && full2) ||
                (dict3_write_enable && full3)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Value storage is unreset; the valid bits alone decide what can match.
    always_ff @(posedge clk) begin
        if (!dict_clear && wr1) mem1_q[ptr1_q[FIELD1_KEY_WIDTH-1:0]] <= dict1_write_val;
        if (!dict_clear && wr2) mem2_q[ptr2_q[FIELD2_KEY_WIDTH-1:0]] <= dict2_write_val;
        if (!dict_clear && wr3) mem3_q[ptr3_q[FIELD3_KEY_WIDTH-1:0]] <= dict3_write_val;
    end

    logic [FIELD1_VAL_WIDTH-1:0] f1;
    logic [FIELD2_VAL_WIDTH-1:0] f2;
    logic [FIELD3_VAL_WIDTH-1:0] f3;
    logic                        hit1, hit2, hit3;
    logic [FIELD1_KEY_WIDTH-1:0] key1;
    logic [FIELD2_KEY_WIDTH-1:0] key2;
    logic [FIELD3_KEY_WIDTH-1:0] key3;

    assign f1 = s1_instr_q[FIELD1_VAL_WIDTH-1:0];
    assign f2 = s1_instr_q[FIELD1_VAL_WIDTH +: FIELD2_VAL_WIDTH];
    assign f3 = s1_instr_q[FIELD1_VAL_WIDTH+FIELD2_VAL_WIDTH +: FIELD3_VAL_WIDTH];

    // Scanning from the top down lets the lowest matching index win.
    always_comb begin
        hit1 = 1'b0;
        key1 = '0;
        for (int i = D1-1; i >= 0; i--) begin
            if (vld1_q[i] && (mem1_q[i] == f1)) begin
                hit1 = 1'b1;
                key1 = i[FIELD1_KEY_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        hit2 = 1'b0;
        key2 = '0;
        for (int i = D2-1; i >= 0; i--) begin
            if (vld2_q[i] && (mem2_q[i] == f2)) begin
                hit2 = 1'b1;
                key2 = i[FIELD2_KEY_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        hit3 = 1'b0;
        key3 = '0;
        for (int i = D3-1; i >= 0; i--) begin
            if (vld3_q[i] && (mem3_q[i] == f3)) begin
                hit3 = 1'b1;
                key3 = i[FIELD3_KEY_WIDTH-1:0];
            end
        end
    end

    logic hit;
    assign hit      = hit1 && hit2 && hit3;
    assign stall    = out_valid_q && !out_ready;
    assign transfer = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q   <= 1'b0;
            s1_instr_q   <= '0;
            out_valid_q  <= 1'b0;
            out_hit_q    <= 1'b0;
            out_data_q   <= '0;
            stat_total_q <= '0;
            stat_hits_q  <= '0;
        end else begin
            if (!stall) begin
                s1_valid_q  <= in_valid;
                out_valid_q <= s1_valid_q;
                if (in_valid) s1_instr_q <= in_instr;
                if (s1_valid_q) begin
                    out_hit_q  <= hit;
                    out_data_q <= hit ? {{(32-KEYS_W){1'b0}}, key3, key2, key1} : s1_instr_q;
                end
            end
            if (transfer) begin
                if (stat_total_q != 32'hFFFF_FFFF) stat_total_q <= stat_total_q + 1'b1;
                if (out_hit_q && (stat_hits_q != 32'hFFFF_FFFF)) stat_hits_q <= stat_hits_q + 1'b1;
            end
        end
    end

    assign in_ready      = !stall;
    assign out_valid     = out_valid_q;
    assign out_hit       = out_hit_q;
    assign out_data      = out_data_q;
    assign stat_total    = stat_total_q;
    assign stat_hits     = stat_hits_q;
    assign dict_overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_compressor.sv
// tb_instr_compressor: directed stimulus with a queue scoreboard checked by an output monitor.
`default_nettype none

module tb_instr_compressor;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dict_clear;
    logic        dict1_write_enable;
    logic [6:0]  dict1_write_val;
    logic        dict2_write_enable;
    logic [9:0]  dict2_write_val;
    logic        dict3_write_enable;
    logic [14:0] dict3_write_val;
    logic        dict_overflow;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [31:0] out_data;
    logic [31:0] stat_total;
    logic [31:0] stat_hits;

    always #5 clk = ~clk;

    instr_compressor dut (
        .clk                (clk),
        .resetn             (resetn),
        .dict_clear         (dict_clear),
        .dict1_write_enable (dict1_write_enable),
        .dict1_write_val    (dict1_write_val),
        .dict2_write_enable (dict2_write_enable),
        .dict2_write_val    (dict2_write_val),
        .dict3_write_enable (dict3_write_enable),
        .dict3_write_val    (dict3_write_val),
        .dict_overflow      (dict_overflow),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_instr           (in_instr),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_hit            (out_hit),
        .out_data           (out_data),
        .stat_total         (stat_total),
        .stat_hits          (stat_hits)
    );

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   received = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            received++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_hit", {31'b0, out_hit}, {31'b0, mon_e.hit});
                check("out_data", out_data, mon_e.data);
            end
        end
    end

    task automatic wr(input int d, input logic [14:0] v);
        case (d)
            1: begin dict1_write_enable = 1'b1; dict1_write_val = v[6:0]; end
            2: begin dict2_write_enable = 1'b1; dict2_write_val = v[9:0]; end
            default: begin dict3_write_enable = 1'b1; dict3_write_val = v; end
        endcase
        @(posedge clk); #1;
        dict1_write_enable = 1'b0;
        dict2_write_enable = 1'b0;
        dict3_write_enable = 1'b0;
    endtask

    task automatic clear_dicts();
        dict_clear = 1'b1;
        @(posedge clk); #1;
        dict_clear = 1'b0;
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send(input logic [31:0] instr, input logic hit, input logic [31:0] data,
                        input bit push);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for %h", instr);
        end else if (push) begin
            sb_q.push_back({hit, data});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        int          rec;
        resetn             = 1'b0;
        dict_clear         = 1'b0;
        dict1_write_enable = 1'b0;
        dict1_write_val    = '0;
        dict2_write_enable = 1'b0;
        dict2_write_val    = '0;
        dict3_write_enable = 1'b0;
        dict3_write_val    = '0;
        in_valid           = 1'b0;
        in_instr           = '0;
        out_ready          = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_hit", {31'b0, out_hit}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_stat_total", stat_total, 32'd0);
        check("rst_stat_hits", stat_hits, 32'd0);
        check("rst_overflow", {31'b0, dict_overflow}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic hit with key3 pointing at an all-zero entry.
        wr(1, 15'h13); wr(1, 15'h33); wr(1, 15'h03);
        wr(2, 15'h000); wr(2, 15'h001);
        wr(3, 15'h1111); wr(3, 15'h2222); wr(3, 15'h3333); wr(3, 15'h4444); wr(3, 15'h0000);
        send(32'h0000_0013, 1'b1, 32'h0000_0400, 1'b1);
        check("lat_not_yet", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("lat_data", out_data, 32'h0000_0400);
        drain();

        send(32'h0000_006F, 1'b0, 32'h0000_006F, 1'b1);
        drain();
        check("stat_total_2", stat_total, 32'd2);
        check("stat_hits_1", stat_hits, 32'd1);

        // Overflow on the ninth write, cleared by dict_clear.
        clear_dicts();
        for (int i = 0; i < 9; i++) begin
            wr(1, 15'(8'h40 + i));
            if (i == 7) check("ovf_at_8", {31'b0, dict_overflow}, 32'd0);
        end
        check("ovf_at_9", {31'b0, dict_overflow}, 32'd1);
        clear_dicts();
        check("ovf_cleared", {31'b0, dict_overflow}, 32'd0);
        send(32'h0000_0013, 1'b0, 32'h0000_0013, 1'b1);
        drain();

        // Duplicate 0x13 at indices 2 and 5; field boundaries with nonzero keys.
        wr(1, 15'h01); wr(1, 15'h02); wr(1, 15'h13); wr(1, 15'h04); wr(1, 15'h05); wr(1, 15'h13);
        wr(2, 15'h000); wr(2, 15'h155);
        wr(3, 15'h0000); wr(3, 15'h7FFF);
        send(32'h0000_0013, 1'b1, 32'h0000_0002, 1'b1);
        send(32'hFFFE_AA93, 1'b1, 32'h0000_010A, 1'b1);
        drain();
        check("stat_total_5", stat_total, 32'd5);
        check("stat_hits_3", stat_hits, 32'd3);

        // Back-to-back stream with a 3-cycle backpressure window.
        fork
            begin
                send(32'h0000_0013, 1'b1, 32'h0000_0002, 1'b1);
                send(32'hFFFE_AA93, 1'b1, 32'h0000_010A, 1'b1);
                send(32'h0000_006F, 1'b0, 32'h0000_006F, 1'b1);
                send(32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                check("stall_data_first", held, 32'h0000_0002);
                repeat (2) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    check("stall_data_held", out_data, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stat_total_9", stat_total, 32'd9);
        check("stat_hits_5", stat_hits, 32'd5);
        check("sb_empty", sb_q.size(), 32'd0);

        // Reset while two instructions are in flight.
        out_ready = 1'b0;
        send(32'h0000_0013, 1'b1, 32'h0000_0002, 1'b0);
        send(32'h0000_006F, 1'b0, 32'h0000_006F, 1'b0);
        check("inflight_valid", {31'b0, out_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_total", stat_total, 32'd0);
        check("mid_rst_hits", stat_hits, 32'd0);
        @(posedge clk); #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        rec       = received;
        repeat (6) @(posedge clk);
        #1;
        check("no_output_after_rst", received, rec);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_total", stat_total, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_compressor.md
Name: instr_compressor

Overview:
- Dictionary-based instruction compressor; the encode-side counterpart of the decompressing cache controller.
- Accepts 32-bit instructions over a valid/ready stream and splits each into three fields.
- Looks each field up in three loadable dictionaries and emits either a 16-bit key triple or the raw 32-bit word.
- Sits in the offline/packing path that produces compressed program images; its dictionaries load through the same sequential write-enable/value port protocol the controller uses.

Parameters:
FIELD1_VAL_WIDTH, 7, field1 width = instr[6:0]
FIELD2_VAL_WIDTH, 10, field2 width = instr[16:7]
FIELD3_VAL_WIDTH, 15, field3 width = instr[31:17]
FIELD1_KEY_WIDTH, 3, dict1 depth 2**3 = 8
FIELD2_KEY_WIDTH, 5, dict2 depth 32
FIELD3_KEY_WIDTH, 8, dict3 depth 256

Ports:
clk  in  1  clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
dict_clear  in  1  synchronous; empties all three dictionaries
dict1_write_enable  in  1  append dict1_write_val at dict1 write pointer
dict1_write_val  in  7  dict1 entry
dict2_write_enable  in  1  append to dict2
dict2_write_val  in  10  dict2 entry
dict3_write_enable  in  1  append to dict3
dict3_write_val  in  15  dict3 entry
dict_overflow  out  1  sticky: a write was attempted to a full dictionary
in_valid  in  1  instruction valid
in_ready  out  1  compressor can accept
in_instr  in  32  instruction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_hit  out  1  1 = all three fields found
out_data  out  32  hit: {16'b0, key3[7:0], key2[4:0], key1[2:0]}; miss: in_instr verbatim
stat_total  out  32  instructions emitted, saturating
stat_hits  out  32  hits emitted, saturating

Behaviour:
- Reset (async, resetn=0): all write pointers=0, all entry-valid bits=0, dict_overflow=0, both pipeline valids=0, out_valid=0, out_hit=0, out_data=0, stat_total=0, stat_hits=0. in_ready=1 once out of reset. Dictionary value storage need not reset.
- Dictionary load: each dictionary has an independent write pointer. On clk with dictN_write_enable=1 and pointer<depth: store value at pointer, set that entry's valid bit, pointer+1. Pointer==depth: write dropped, dict_overflow<=1 (sticky until reset or dict_clear). All three dictionaries may be written in the same cycle.
- dict_clear: pointers<=0, valid bits<=0, dict_overflow<=0. dict_clear beats a write in the same cycle. Pipeline contents are unaffected.
- Only entries with valid bit=1 match. Unwritten entries never match, including an all-zero value.
- Pipeline has two stages, S1 (compare) and S2 (output register). Latency is 2 cycles from accepted input to out_valid with no backpressure. Throughput is 1 per cycle.
- S1 captures in_instr on in_valid&&in_ready.
- S1 compares each field in parallel against every valid entry of its dictionary. The key is the lowest matching index (priority encode). hit = all three fields matched.
- S1->S2 on advance: out_hit=hit, out_data per port definition.
- Stall: stall = out_valid && !out_ready. While stalled, S1 and S2 hold and in_ready=0. in_ready = !stall. The combinational in_ready path is allowed.
- Compare/write ordering: the compare uses dictionary state as registered at the start of the S1 cycle. A write in the same cycle is not visible to that compare. A stalled S1 entry re-evaluates each cycle against current contents; its result is taken on the advancing cycle.
- Output handshake: out_valid && out_ready = transfer. On transfer, stat_total+1 and, if out_hit, stat_hits+1. Both counters saturate at 32'hFFFF_FFFF.
- out_data/out_hit are held stable while out_valid && !out_ready.
- Reset asserted mid-stream drops in-flight instructions; no output is produced for them.

Test Plan:
- Reset, then load dict1={0x13,0x33,0x03}, dict2[0..1]={0x000,0x001}, dict3[0..4] with entry4=0x0000; send 0x00000013 -> 2 cycles later out_valid=1, out_hit=1, out_data=0x00000400 (key3=4, key2=0, key1=0).
- Same dictionaries; send 0x0000006F (field1 not loaded) -> out_hit=0, out_data=0x0000006F; stat_total=2, stat_hits=1 after both transfer.
- Load dict1 with 9 writes -> 9th dropped, dict_overflow=1; dict_clear -> dict_overflow=0; resend 0x00000013 -> out_hit=0.
- Duplicate value 0x13 at dict1 indices 2 and 5 -> key1=2 (lowest index wins).
- Stream 4 back-to-back instructions with out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, out_data held, all 4 emitted in order, none lost or duplicated.
- Assert resetn=0 for 1 cycle while 2 instructions are in flight -> out_valid=0 immediately, stat counters=0, no output for those instructions.
